// File: rtl/vermicodes_pkg.sv
// Vermicel encodings: RV32M funct3 op codes and multiply/divide timing constants.
package Vermicodes_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_op_t;

   localparam int MULDIV_ITERATIONS = 32;
   localparam int MULDIV_LATENCY    = 34;

endpackage

// File: rtl/vermitypes_pkg.sv
// Shared Vermicel data types: the machine word and the multiply/divide FSM states.
package Vermitypes_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DONE   = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit, one bit per cycle, fixed 34-cycle latency.
// Define VERMICEL_MULDIV_DIV_EN to build the divider; otherwise division ops complete at once as illegal.
module muldiv_unit
   import Vermitypes_pkg::*;
   import Vermicodes_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] funct3,
   input  word_t      a,
   input  word_t      b,
   output logic       busy,
   output logic       done,
   output word_t      result,
   output logic       illegal
);

   muldiv_state_t      state_q, state_d;
   muldiv_op_t         op_q;
   logic [4:0]         count_q;
   word_t              opa_q;
   logic [2*WIDTH-1:0] prod_q;
   logic               neg_q;
   logic               accept, illegal_op, last_iter;
   logic               sign_a, sign_b;
   word_t              mag_a, mag_b, mulh_hi;
   logic [WIDTH:0]     mul_sum;

   assign accept    = start && (state_q == IDLE || state_q == DONE);
   assign last_iter = (count_q == 5'(MULDIV_ITERATIONS - 1));
   assign sign_a    = a[WIDTH-1] && (funct3 == MULH || funct3 == MULHSU || funct3 == DIV || funct3 == REM);
   assign sign_b    = b[WIDTH-1] && (funct3 == MULH || funct3 == DIV || funct3 == REM);
   assign mag_a     = sign_a ? -a : a;
   assign mag_b     = sign_b ? -b : b;

   // Shift-add step: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
   // High half of the negated 64-bit product: borrow only propagates when the low half is zero.
   assign mulh_hi = neg_q ? (~prod_q[2*WIDTH-1:WIDTH] + word_t'(prod_q[WIDTH-1:0] == '0))
                          : prod_q[2*WIDTH-1:WIDTH];

`ifdef VERMICEL_MULDIV_DIV_EN
   word_t            opb_q, quot_fix, rem_fix;
   logic             nega_q, div_zero_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH+1:0] rem_shift, trial;

   assign illegal_op = 1'b0;
   assign illegal    = 1'b0;
   assign rem_shift  = {rem_q, prod_q[WIDTH-1]};
   assign trial      = rem_shift - {2'b00, opb_q};
   assign quot_fix   = neg_q  ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
   assign rem_fix    = nega_q ? -rem_q[WIDTH-1:0]  : rem_q[WIDTH-1:0];
`else
   logic illegal_q;

   assign illegal_op = funct3[2];
   assign illegal    = illegal_q;
`endif

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assignment first, so no path leaves state_d unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: state_d = accept ? (illegal_op ? DONE : RUN) : IDLE;
         RUN:        if (last_iter) state_d = FINISH;
         FINISH:     state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN) || (state_q == FINISH);
   assign done = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= MUL;
         count_q    <= '0;
         opa_q      <= '0;
         prod_q     <= '0;
         neg_q      <= 1'b0;
         result     <= '0;
`ifdef VERMICEL_MULDIV_DIV_EN
         opb_q      <= '0;
         nega_q     <= 1'b0;
         div_zero_q <= 1'b0;
         rem_q      <= '0;
`else
         illegal_q  <= 1'b0;
`endif
      end else begin
`ifndef VERMICEL_MULDIV_DIV_EN
         illegal_q <= accept && illegal_op;
`endif
         if (accept) begin
            op_q    <= muldiv_op_t'(funct3);
            count_q <= '0;
            opa_q   <= mag_a;
            neg_q   <= sign_a ^ sign_b;
            prod_q  <= {{WIDTH{1'b0}}, mag_b};
`ifdef VERMICEL_MULDIV_DIV_EN
            opb_q      <= mag_b;
            nega_q     <= sign_a;
            div_zero_q <= (b == '0);
            rem_q      <= '0;
            if (funct3[2]) prod_q <= {{WIDTH{1'b0}}, mag_a};
`else
            if (illegal_op) result <= '0;
`endif
         end else if (state_q == RUN) begin
            count_q <= count_q + 5'd1;
`ifdef VERMICEL_MULDIV_DIV_EN
            if (op_q[2]) begin
               // Restoring step: keep the trial difference only when it did not go negative.
               prod_q[WIDTH-1:0] <= {prod_q[WIDTH-2:0], ~trial[WIDTH+1]};
               rem_q             <= trial[WIDTH+1] ? rem_shift[WIDTH:0] : trial[WIDTH:0];
            end else begin
               prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
            end
`else
            prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
`endif
         end else if (state_q == FINISH) begin
            unique case (op_q)
               MUL:                result <= prod_q[WIDTH-1:0];
               MULH, MULHSU, MULHU: result <= mulh_hi;
`ifdef VERMICEL_MULDIV_DIV_EN
               // Overflow (MIN / -1) falls out of the magnitude path as MIN with remainder 0.
               DIV, DIVU:          result <= div_zero_q ? '1 : quot_fix;
               // A zero divisor leaves |a| as remainder; the sign fix restores a itself.
               REM, REMU:          result <= rem_fix;
`endif
               default:            result <= '0;
            endcase
         end
      end
   end

endmodule
